// File: rtl/nand4_sweep_ctrl.sv
// Exhaustive-sweep checker for 4-input gate variants: steps the DUV through every
// input vector, samples its output after a settle delay and scores it against EXPECT.
module nand4_sweep_ctrl #(
  parameter int                    N_IN       = 4,
  parameter int                    SETTLE_CYC = 2,
  parameter logic [2**N_IN-1:0]    EXPECT     = 16'h7FFF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic            i_f,
  output logic [N_IN-1:0] o_vec,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_cnt,
  output logic            o_first_err_valid,
  output logic [N_IN-1:0] o_first_err_vec
);

  localparam int              CNT_W    = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [N_IN:0]   ERR_MAX  = (N_IN+1)'(2**N_IN);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [N_IN-1:0]   vec;
  logic [N_IN:0]     err_cnt, err_cnt_nxt;
  logic              pass;
  logic              fev_vld;
  logic [N_IN-1:0]   fev;
  logic              mismatch;

  function automatic logic [N_IN:0] sat_inc(input logic [N_IN:0] v);
    if (v == ERR_MAX) return v;
    return v + (N_IN+1)'(1);
  endfunction

  // X/Z on the DUV output must count as a failure, hence the case inequality.
  assign mismatch    = (state == CHECK) && (i_f !== EXPECT[vec]);
  assign err_cnt_nxt = mismatch ? sat_inc(err_cnt) : err_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_start) state_nxt = SETTLE;
        SETTLE:  if (cnt == CNT_W'(SETTLE_CYC - 1)) state_nxt = CHECK;
        CHECK:   state_nxt = (vec == LAST_VEC) ? DONE : SETTLE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      vec     <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
      fev_vld <= 1'b0;
      fev     <= '0;
    end else begin
      case (state)
        IDLE: begin
          vec <= '0;
          if (i_start && !i_abort) begin
            cnt     <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
            fev_vld <= 1'b0;
            fev     <= '0;
          end
        end
        SETTLE: cnt <= cnt + CNT_W'(1);
        CHECK: begin
          cnt     <= '0;
          err_cnt <= err_cnt_nxt;
          if (mismatch && !fev_vld) begin
            fev_vld <= 1'b1;
            fev     <= vec;
          end
          // Verdict uses the updated count so a failing last vector is included.
          if (vec == LAST_VEC) pass <= (err_cnt_nxt == '0);
          else                 vec  <= vec + N_IN'(1);
        end
        DONE:    vec <= '0;
        default: vec <= '0;
      endcase
      // Abort keeps partial error data but never leaves a pass verdict behind.
      if (i_abort && state != IDLE) begin
        vec  <= '0;
        pass <= 1'b0;
      end
    end
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (state)
      SETTLE, CHECK: o_busy = 1'b1;
      DONE:          o_done = !i_abort;
      default:       ;
    endcase
  end

  assign o_vec             = vec;
  assign o_pass            = pass;
  assign o_err_cnt         = err_cnt;
  assign o_first_err_valid = fev_vld;
  assign o_first_err_vec   = fev;

endmodule
